// File: rtl/down_counter_timer_if.sv
// Load handshake, count controls and status of the loadable down-counter/timer.
// master = requester/controller side, slave = timer side.
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             enable;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_value, enable, abort,
    input  load_ready, count, busy, done
  );

  modport slave (
    input  load_valid, load_value, enable, abort,
    output load_ready, count, busy, done
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with valid/ready load and a one-cycle done pulse.
// Optional periodic mode: define DOWN_COUNTER_AUTORELOAD_EN to reload the last
// accepted start value on terminal count instead of returning to IDLE.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic reset,
  down_counter_timer_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic             done_q, done_n;
  logic             busy_q;
  logic             accept;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_n;
`endif

  // Loads are only taken while idle; a requester holds load_valid until then.
  assign accept = bus.load_valid && (state == IDLE);

  // Next-state / next-count: abort beats enable and terminal count in RUN.
  always_comb begin
    state_n  = state;
    count_n  = count_q;
    done_n   = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    reload_n = reload_q;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
          reload_n = bus.load_value;
`endif
          if (bus.load_value != ZERO) begin
            count_n = bus.load_value;
            state_n = RUN;
          end else begin
            // Zero-length delay: expire immediately without entering RUN.
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          count_n = ZERO;
          state_n = IDLE;
        end else if (bus.enable) begin
          if (count_q == ONE) begin
            done_n = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            count_n = reload_q;
`else
            count_n = ZERO;
            state_n = IDLE;
`endif
          end else begin
            count_n = count_q - ONE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        count_n = ZERO;
      end
    endcase
  end

  // State and registered outputs; reset discards any countdown in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count_q  <= ZERO;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_q <= ZERO;
`endif
    end else begin
      state    <= state_n;
      count_q  <= count_n;
      done_q   <= done_n;
      busy_q   <= (state_n == RUN);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_q <= reload_n;
`endif
    end
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.count      = count_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule
